// File: rtl/pwm_channel_ctrl.sv
// Multi-channel PWM controller. Configuration writes land in per-channel shadow
// registers and are committed at period boundaries, so the outputs never show runt pulses.
// pwm_config_vld is a one-cycle strobe with no ready: every strobe is consumed in the cycle it is seen.
module pwm_channel_ctrl #(
    parameter int CH_NUM = 8,
    parameter int CNT_W  = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_config_vld,
    input  logic [7:0]        pwm_config_channel,
    input  logic              pwm_en,
    input  logic [CNT_W-1:0]  pwm_period,
    input  logic [CNT_W-1:0]  pwm_hlevel,
    output logic [CH_NUM-1:0] pwm_out,
    output logic [CH_NUM-1:0] cfg_pending,
    output logic              cfg_err
);

    logic cfg_ok;

    // Widened by one bit so that CH_NUM=256 still compares correctly.
    assign cfg_ok = ({1'b0, pwm_config_channel} < 9'(CH_NUM));

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= pwm_config_vld && !cfg_ok;
        end
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic             sh_en;
        logic [CNT_W-1:0] sh_period;
        logic [CNT_W-1:0] sh_hlevel;
        logic             act_en;
        logic [CNT_W-1:0] act_period;
        logic [CNT_W-1:0] act_hlevel;
        logic [CNT_W-1:0] cnt;
        logic             pend;
        logic             pwm_q;
        logic             wr;
        logic             running;
        logic             last;
        logic             apply_point;

        always_comb begin
            wr          = pwm_config_vld && cfg_ok && (pwm_config_channel == 8'(i));
            running     = act_en && (act_period != '0);
            last        = running && (cnt == act_period - CNT_W'(1));
            // Idle channels take a pending config at once; running ones wait for the boundary.
            apply_point = running ? last : pend;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sh_en      <= 1'b0;
                sh_period  <= '0;
                sh_hlevel  <= '0;
                act_en     <= 1'b0;
                act_period <= '0;
                act_hlevel <= '0;
                cnt        <= '0;
                pend       <= 1'b0;
                pwm_q      <= 1'b0;
            end else begin
                if (apply_point && wr) begin
                    // A write arriving exactly at the commit edge goes straight to active.
                    act_en     <= pwm_en;
                    act_period <= pwm_period;
                    act_hlevel <= pwm_hlevel;
                    pend       <= 1'b0;
                    cnt        <= '0;
                end else if (apply_point && pend) begin
                    act_en     <= sh_en;
                    act_period <= sh_period;
                    act_hlevel <= sh_hlevel;
                    pend       <= 1'b0;
                    cnt        <= '0;
                end else begin
                    if (wr) begin
                        sh_en     <= pwm_en;
                        sh_period <= pwm_period;
                        sh_hlevel <= pwm_hlevel;
                        pend      <= 1'b1;
                    end
                    if (running && !last) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                pwm_q <= running && (cnt < act_hlevel);
            end
        end

        assign pwm_out[i]     = pwm_q;
        assign cfg_pending[i] = pend;
    end

endmodule
